// File: rtl/ky32_arith_pkg.sv
// rtl/ky32_arith_pkg.sv - shared widths and requester-id type for the KY32 arithmetic blocks
package ky32_arith_pkg;
  localparam int W    = 32;
  localparam int NREQ = 2;
  typedef logic [0:0] req_id_t;
endpackage

// File: rtl/KY32_cla32.sv
// rtl/KY32_cla32.sv - two-level carry-lookahead adder, 4-bit groups
module KY32_cla32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c,
  output logic [W-1:0] s
);
  localparam int NG = W / 4;

  logic [W-1:0]  g, p, cy;
  logic [NG-1:0] gg, gp;
  logic [NG:0]   gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    cy = '0;
    for (int k = 0; k < NG; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Group carries come from group G/P only; bit carries are resolved inside each group.
    gc[0] = c;
    for (int k = 0; k < NG; k++)
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    for (int k = 0; k < NG; k++) begin
      cy[4*k] = gc[k];
      for (int j = 0; j < 3; j++)
        cy[4*k+j+1] = g[4*k+j] | (p[4*k+j] & cy[4*k+j]);
    end
    s = p ^ cy;
  end
endmodule

// File: rtl/ky32_add_arb.sv
// rtl/ky32_add_arb.sv - two-requester round-robin arbiter in front of one shared CLA adder
module ky32_add_arb #(
  parameter int W    = ky32_arith_pkg::W,
  parameter int NREQ = ky32_arith_pkg::NREQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic            req0_sub,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  input  logic            req1_sub,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [W-1:0]    rsp_s
);
  import ky32_arith_pkg::req_id_t;

  req_id_t     last_grant;
  req_id_t     gnt;
  logic        slot_free;
  logic        accept;
  logic [W-1:0] op_a, op_b, b_eff, sum;
  logic        op_sub;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    gnt = 1'b0;
    if (req_valid[0] && req_valid[1])
      gnt = ~last_grant;
    else if (req_valid[1])
      gnt = 1'b1;
  end

  assign slot_free = !rsp_valid || rsp_ready;

  always_comb begin
    req_ready = '0;
    if (!rst && slot_free && (|req_valid))
      req_ready[gnt] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    op_a   = gnt[0] ? req1_a   : req0_a;
    op_b   = gnt[0] ? req1_b   : req0_b;
    op_sub = gnt[0] ? req1_sub : req0_sub;
    b_eff  = op_sub ? ~op_b : op_b;
  end

  KY32_cla32 #(.W(W)) u_cla (
    .a (op_a),
    .b (b_eff),
    .c (op_sub),
    .s (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_s      <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_s      <= sum;
      rsp_id     <= gnt[0];
      last_grant <= gnt;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ky32_add_arb.sv
// tb/tb_ky32_add_arb.sv - directed literal checks plus randomized run against a behavioural model
module tb_ky32_add_arb;
  logic        clk, rst;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp_s;
  logic        req0_sub, req1_sub, rsp_valid, rsp_ready, rsp_id;

  int checks = 0;
  int failures = 0;

  ky32_add_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: one result slot, round-robin winner, result = a +/- b.
  logic        m_valid, m_id, m_last;
  logic [31:0] m_s;
  initial begin : model
    logic [1:0]  exp_ready;
    logic        win, n_valid, n_id, n_last;
    logic [31:0] n_s;
    m_valid = 0; m_s = 0; m_id = 0; m_last = 1;
    forever begin
      @(negedge clk);
      exp_ready = 2'b00;
      win = 1'b0;
      if (rst) begin
        m_valid = 0; m_s = 0; m_id = 0; m_last = 1;
      end else if ((!m_valid || rsp_ready) && req_valid != 2'b00) begin
        win = (req_valid == 2'b11) ? !m_last : req_valid[1];
        exp_ready = win ? 2'b10 : 2'b01;
      end
      chk("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      chk("rsp_id",    {31'd0, rsp_id},    {31'd0, m_id});
      chk("rsp_s",     rsp_s,              m_s);
      n_valid = m_valid; n_s = m_s; n_id = m_id; n_last = m_last;
      if (exp_ready != 2'b00) begin
        n_valid = 1;
        n_id    = win;
        n_last  = win;
        if (win) n_s = req1_sub ? req1_a - req1_b : req1_a + req1_b;
        else     n_s = req0_sub ? req0_a - req0_b : req0_a + req0_b;
      end else if (rsp_ready) begin
        n_valid = 0;
      end
      @(posedge clk);
      if (!rst) begin
        m_valid = n_valid; m_s = n_s; m_id = n_id; m_last = n_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: rand_op = 32'h0000_0000;
      1: rand_op = 32'hFFFF_FFFF;
      2: rand_op = 32'h8000_0000;
      3: rand_op = 32'h0000_0001;
      default: rand_op = $urandom;
    endcase
  endfunction

  initial begin : stim
    logic [31:0] held_s;
    rst = 1; req_valid = 0; rsp_ready = 1;
    req0_a = 0; req0_b = 0; req0_sub = 0; req1_a = 0; req1_b = 0; req1_sub = 0;
    repeat (3) tick();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_s", rsp_s, 32'd0);

    // First accept in the very first cycle out of reset
    rst = 0; req_valid = 2'b01; req0_a = 32'h5; req0_b = 32'h3; req0_sub = 0;
    tick();
    chk("t031_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t031_s", rsp_s, 32'h8);
    chk("t031_id", {31'd0, rsp_id}, 32'd0);

    req_valid = 2'b10; req1_a = 32'h0; req1_b = 32'h1; req1_sub = 1;
    tick();
    chk("t032_sub_s", rsp_s, 32'hFFFF_FFFF);
    chk("t032_sub_id", {31'd0, rsp_id}, 32'd1);
    req1_a = 32'hFFFF_FFFF; req1_b = 32'h1; req1_sub = 0;
    tick();
    chk("t032_wrap_s", rsp_s, 32'h0);

    // Both valid: strict alternation starting with requester 0
    req_valid = 2'b11;
    req0_a = 32'd10; req0_b = 32'd1; req0_sub = 0;
    req1_a = 32'd10; req1_b = 32'd1; req1_sub = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t033_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t033_id", {31'd0, rsp_id}, i[0] ? 32'd1 : 32'd0);
      chk("t033_s", rsp_s, i[0] ? 32'd9 : 32'd11);
    end

    // Stall: outputs hold, nobody is accepted
    rsp_ready = 0;
    held_s = 32'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t034_ready", {30'd0, req_ready}, 32'd0);
      chk("t034_id", {31'd0, rsp_id}, 32'd1);
      chk("t034_s", rsp_s, held_s);
      tick();
    end
    rsp_ready = 1;
    #1;
    chk("t034_regrant", {30'd0, req_ready}, 32'd1);
    tick();
    chk("t034_next_id", {31'd0, rsp_id}, 32'd0);
    chk("t034_next_s", rsp_s, 32'd11);

    // Reset with a pending result
    req_valid = 2'b00; rsp_ready = 0;
    tick();
    rst = 1;
    #1;
    chk("t035_async_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    rst = 0; req_valid = 2'b11; rsp_ready = 1;
    #1;
    chk("t035_grant0", {30'd0, req_ready}, 32'd1);
    tick();
    chk("t035_id", {31'd0, rsp_id}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      tick();
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = 2'($urandom_range(0, 3));
      req0_a = rand_op(); req0_b = rand_op(); req0_sub = 1'($urandom_range(0, 1));
      req1_a = rand_op(); req1_b = rand_op(); req1_sub = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    tick();
    rst = 0; req_valid = 0; rsp_ready = 1;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ky32_add_arb.md
KY32_ADD_ARB -- requirements
Module: ky32_add_arb

Interface
REQ-001 SHALL have parameter W, default 32: operand/result width, fixed at 32 for the KY32_cla32 datapath.
REQ-002 SHALL have parameter NREQ, default 2: number of requesters, fixed at 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 2: per-requester request valid.
REQ-006 SHALL have port req_ready, output, 2: per-requester accept; at most one bit high in any cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32 each: operands per requester.
REQ-008 SHALL have ports req0_sub, req1_sub, input, 1 each: 0 selects a+b, 1 selects a-b.
REQ-009 SHALL have port rsp_valid, output, 1: result register holds a valid result.
REQ-010 SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port rsp_id, output, 1: index of the requester that owns the result.
REQ-012 SHALL have port rsp_s, output, 32: the result.

Function
REQ-013 SHALL share one 32-bit carry-lookahead adder between both requesters.
REQ-014 SHALL compute s = a + b + 0 when sub=0, and s = a + ~b + 1 when sub=1, modulo 2^32; no carry/overflow output.
REQ-015 Accept condition SHALL be req_valid[i] & req_ready[i]; a request is transferred on the rising clk edge where the condition holds.
REQ-016 Slot-free SHALL mean !rsp_valid | rsp_ready.
REQ-017 req_ready[i] SHALL be high only when slot-free holds and requester i is granted; it is a combinational function of req_valid, rsp_valid, rsp_ready and the round-robin pointer.
REQ-018 Grant SHALL go to the sole valid requester; if both are valid, it goes to the requester != last_grant.
REQ-019 last_grant SHALL update only on an accept.
REQ-020 On accept, the result register SHALL load s and rsp_id = i, and rsp_valid SHALL be 1 in the next cycle (latency 1 cycle).
REQ-021 If rsp_valid & rsp_ready and there is no accept in the same cycle, rsp_valid SHALL be 0 in the next cycle.
REQ-022 Simultaneous drain and accept SHALL sustain 1 result per cycle.
REQ-023 While rsp_valid & !rsp_ready: rsp_s and rsp_id SHALL hold stable, and req_ready SHALL be 2'b00.
REQ-024 A requester SHALL NOT be starved: with both requesters continuously valid, grants strictly alternate.

Reset
REQ-025 While rst=1: rsp_valid=0, rsp_s=0, rsp_id=0, last_grant=1 (requester 0 wins first), req_ready=2'b00.
REQ-026 Asserting rst mid-operation SHALL discard a pending result with no response emitted.
REQ-027 The first accept after rst deasserts SHALL be possible in the first clock cycle.

Structure
REQ-028 W, NREQ and the requester-id type SHALL live in the shared package ky32_arith_pkg.
REQ-029 The block SHALL contain exactly one sub-module instance, KY32_cla32 (inputs a, b, c; output s); operand mux and ~b inversion sit in front of it.
REQ-030 Arbitration and the result register SHALL be in ky32_add_arb itself; no second adder is permitted.

Verification
REQ-031 After rst, req0 valid, a=0x00000005, b=0x00000003, sub=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_s=0x00000008, rsp_id=0.
REQ-032 req1 a=0x00000000, b=0x00000001, sub=1 -> rsp_s=0xFFFFFFFF, rsp_id=1; a=0xFFFFFFFF, b=0x00000001, sub=0 -> rsp_s=0x00000000.
REQ-033 Both valid for 4 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1, one result per cycle.
REQ-034 rsp_ready=0 for 3 cycles with both valid -> req_ready=00, rsp_s/rsp_id stable; then rsp_ready=1 -> next grant in the same cycle.
REQ-035 rst pulse while rsp_valid=1 -> rsp_valid=0 immediately (asynchronous), no response emitted, next grant to requester 0.
